// File: rtl/muldiv_iterative.sv
// muldiv_iterative: multi-cycle RV32M responder.
// It multiplies with shift-add and divides by restoring, one bit per clock.
// Operands are converted to magnitudes when a request is accepted, and the
// stored sign flags correct the result on the final CALC edge.
// The divide-by-zero and signed-overflow cases give the RISC-V defined values.
module muldiv_iterative #(
    parameter int         WIDTH        = 32,
    parameter bit         FAST_SPECIAL = 1'b1,
    parameter logic [4:0] OPMUL        = 5'h10,
    parameter logic [4:0] OPMULH       = 5'h11,
    parameter logic [4:0] OPMULHSU     = 5'h12,
    parameter logic [4:0] OPMULHU      = 5'h13,
    parameter logic [4:0] OPDIV        = 5'h14,
    parameter logic [4:0] OPDIVU       = 5'h15,
    parameter logic [4:0] OPREM        = 5'h16,
    parameter logic [4:0] OPREMU       = 5'h17
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iKill,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oReady,
    output logic             oValid,
    output logic [WIDTH-1:0] oResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0]       LAST_CNT = 5'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    // state and datapath registers
    state_t               state_q,    state_d;
    logic [4:0]           cnt_q,      cnt_d;
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [WIDTH-1:0]     opb_q,      opb_d;
    logic                 mul_q,      mul_d;
    logic                 hi_q,       hi_d;
    logic                 neg_q,      neg_d;
    logic                 special_q,  special_d;
    logic [WIDTH-1:0]     spec_val_q, spec_val_d;
    logic [WIDTH-1:0]     res_q,      res_d;
    logic [WIDTH-1:0]     result_q,   result_d;
    logic                 valid_q,    valid_d;
    logic                 ready_q,    ready_d;

    // request decode
    logic dec_m_s, dec_mul_s, dec_hi_s, dec_rem_s, dec_asg_s, dec_bsg_s;
    // operand preparation
    logic             a_neg_s, b_neg_s, neg_s, div0_s, ovf_s, special_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, spec_val_s;
    // iteration datapath
    logic [WIDTH:0]       mul_sum_s, rem_sh_s, diff_s;
    logic                 qbit_s;
    logic [2*WIDTH-1:0]   mul_next_s, div_next_s, acc_nx_s, prod_fix_s;
    logic [WIDTH-1:0]     raw_res_s, core_res_s;

    // Decode iControl into operation class and operand signedness
    always_comb begin
        dec_m_s   = 1'b0;
        dec_mul_s = 1'b0;
        dec_hi_s  = 1'b0;
        dec_rem_s = 1'b0;
        dec_asg_s = 1'b0;
        dec_bsg_s = 1'b0;
        case (iControl)
            OPMUL:    begin dec_m_s = 1'b1; dec_mul_s = 1'b1; dec_asg_s = 1'b1; dec_bsg_s = 1'b1; end
            OPMULH:   begin dec_m_s = 1'b1; dec_mul_s = 1'b1; dec_hi_s = 1'b1; dec_asg_s = 1'b1; dec_bsg_s = 1'b1; end
            OPMULHSU: begin dec_m_s = 1'b1; dec_mul_s = 1'b1; dec_hi_s = 1'b1; dec_asg_s = 1'b1; end
            OPMULHU:  begin dec_m_s = 1'b1; dec_mul_s = 1'b1; dec_hi_s = 1'b1; end
            OPDIV:    begin dec_m_s = 1'b1; dec_asg_s = 1'b1; dec_bsg_s = 1'b1; end
            OPDIVU:   begin dec_m_s = 1'b1; end
            OPREM:    begin dec_m_s = 1'b1; dec_hi_s = 1'b1; dec_rem_s = 1'b1; dec_asg_s = 1'b1; dec_bsg_s = 1'b1; end
            OPREMU:   begin dec_m_s = 1'b1; dec_hi_s = 1'b1; dec_rem_s = 1'b1; end
            default:  begin dec_m_s = 1'b0; end
        endcase
    end

    // Magnitudes, result sign, and RISC-V special-case values at accept time
    always_comb begin
        a_neg_s   = dec_asg_s & iA[WIDTH-1];
        b_neg_s   = dec_bsg_s & iB[WIDTH-1];
        a_mag_s   = a_neg_s ? ({WIDTH{1'b0}} - iA) : iA;
        b_mag_s   = b_neg_s ? ({WIDTH{1'b0}} - iB) : iB;
        neg_s     = dec_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
        div0_s    = dec_m_s & ~dec_mul_s & (iB == {WIDTH{1'b0}});
        ovf_s     = dec_m_s & ~dec_mul_s & dec_bsg_s & (iA == MIN_NEG) & (iB == {WIDTH{1'b1}});
        special_s = div0_s | ovf_s;
        if (div0_s) begin
            spec_val_s = dec_rem_s ? iA : {WIDTH{1'b1}};
        end else if (ovf_s) begin
            spec_val_s = dec_rem_s ? {WIDTH{1'b0}} : MIN_NEG;
        end else begin
            spec_val_s = {WIDTH{1'b0}};
        end
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the final value
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s     = rem_sh_s - {1'b0, opb_q};
        qbit_s     = ~diff_s[WIDTH];
        div_next_s = {(qbit_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit_s};
        acc_nx_s   = mul_q ? mul_next_s : div_next_s;
        prod_fix_s = neg_q ? ({(2*WIDTH){1'b0}} - acc_nx_s) : acc_nx_s;
        raw_res_s  = hi_q ? acc_nx_s[2*WIDTH-1:WIDTH] : acc_nx_s[WIDTH-1:0];
        if (mul_q) begin
            core_res_s = hi_q ? prod_fix_s[2*WIDTH-1:WIDTH] : prod_fix_s[WIDTH-1:0];
        end else begin
            core_res_s = neg_q ? ({WIDTH{1'b0}} - raw_res_s) : raw_res_s;
        end
    end

    // FSM next state: accept, iterate, publish result; kill returns to IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        mul_d      = mul_q;
        hi_d       = hi_q;
        neg_d      = neg_q;
        special_d  = special_q;
        spec_val_d = spec_val_q;
        res_d      = res_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iKill) begin
                    state_d = S_IDLE;
                end else if (iStart) begin
                    mul_d      = dec_mul_s;
                    hi_d       = dec_hi_s;
                    neg_d      = neg_s;
                    special_d  = special_s;
                    spec_val_d = spec_val_s;
                    cnt_d      = 5'd0;
                    if (dec_mul_s) begin
                        acc_d = {{WIDTH{1'b0}}, b_mag_s};
                        opb_d = a_mag_s;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, a_mag_s};
                        opb_d = b_mag_s;
                    end
                    if (!dec_m_s) begin
                        res_d   = {WIDTH{1'b0}};
                        state_d = S_DONE;
                    end else if (special_s && FAST_SPECIAL) begin
                        res_d   = spec_val_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (iKill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_nx_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        res_d   = special_q ? spec_val_q : core_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                if (iKill) begin
                    state_d = S_IDLE;
                end else begin
                    valid_d  = 1'b1;
                    result_d = res_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= {(2*WIDTH){1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            mul_q      <= 1'b0;
            hi_q       <= 1'b0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= {WIDTH{1'b0}};
            res_q      <= {WIDTH{1'b0}};
            result_q   <= {WIDTH{1'b0}};
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            mul_q      <= mul_d;
            hi_q       <= hi_d;
            neg_q      <= neg_d;
            special_q  <= special_d;
            spec_val_q <= spec_val_d;
            res_q      <= res_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign oReady  = ready_q;
    assign oValid  = valid_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_iterative.sv
// Directed and reference-model bench for muldiv_iterative (FAST_SPECIAL=1).
module tb_muldiv_iterative;

    localparam logic [4:0] OPMUL    = 5'h10;
    localparam logic [4:0] OPMULH   = 5'h11;
    localparam logic [4:0] OPMULHSU = 5'h12;
    localparam logic [4:0] OPMULHU  = 5'h13;
    localparam logic [4:0] OPDIV    = 5'h14;
    localparam logic [4:0] OPDIVU   = 5'h15;
    localparam logic [4:0] OPREM    = 5'h16;
    localparam logic [4:0] OPREMU   = 5'h17;
    localparam logic [4:0] OPADD    = 5'h00;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic        iKill;
    logic [4:0]  iControl;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oReady;
    logic        oValid;
    logic [31:0] oResult;

    int tests = 0;
    int fails = 0;

    muldiv_iterative #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iKill(iKill),
        .iControl(iControl), .iA(iA), .iB(iB),
        .oReady(oReady), .oValid(oValid), .oResult(oResult)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference using native 64-bit and signed SV arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ub;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            OPMUL:    begin p = 64'(sa * sb); return p[31:0]; end
            OPMULH:   begin p = 64'(sa * sb); return p[63:32]; end
            OPMULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            OPMULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            OPDIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                else return 32'(ia / ib);
            end
            OPDIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OPREM:    begin
                if (b == 32'd0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(ia % ib);
            end
            OPREMU:   return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_div, sgn;
        is_div = (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
        sgn    = (op == OPDIV) || (op == OPREM);
        if (op < OPMUL || op > OPREMU) return 1;
        if (is_div && b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request from an idle point (#1 after an edge) and check it end to end
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  n;
        bit  seen;
        check({tag, " ready"}, 32'(oReady), 32'd1);
        iControl = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0; iA = $urandom; iB = $urandom; iControl = OPADD;
        check({tag, " busy"}, 32'(oReady), (exp_lat == 1) ? 32'd0 : 32'd0);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge iCLK); #1;
            n++;
            if (oValid) seen = 1'b1;
        end
        check({tag, " valid_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, oResult, exp);
        @(posedge iCLK); #1;
        check({tag, " pulse_width"}, 32'(oValid), 32'd0);
        check({tag, " held"}, oResult, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic [4:0]  op;
        logic [31:0] a, b;
        int          vcount;

        iRST = 1'b1; iStart = 1'b0; iKill = 1'b0; iControl = 5'd0; iA = 32'd0; iB = 32'd0;
        #1;
        check("reset ready", 32'(oReady), 32'd1);
        check("reset valid", 32'(oValid), 32'd0);
        check("reset result", oResult, 32'd0);
        repeat (2) @(posedge iCLK);
        #3 iRST = 1'b0;
        @(posedge iCLK); #1;

        // multiply
        run_op("mul_7x-3",     OPMUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh_m1",      OPMULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_m1",    OPMULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mulhu_m1",     OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu_-2x3",  OPMULHSU, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);
        // divide
        run_op("div_-7/2",     OPDIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_-7/2",     OPREM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_100/7",   OPDIVU,   32'd100,       32'd7,         32'd14,        33);
        run_op("nonm_op",      OPADD,    32'd5,         32'd9,         32'd0,         1);
        run_op("remu_100/7",   OPREMU,   32'd100,       32'd7,         32'd2,         33);
        // special cases, single-cycle with FAST_SPECIAL=1
        run_op("divu_5/0",     OPDIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_5/0",      OPREM,    32'd5,         32'd0,         32'd5,         1);
        run_op("div_-7/0",     OPDIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("div_ovf",      OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("divu_big",     OPDIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

        // kill at CALC count 10, then back-to-back MUL 3x4
        run_op("mul_pre_kill", OPMUL,    32'd6,         32'd7,         32'd42,        33);
        prev = oResult;
        iControl = OPMUL; iA = 32'h1234; iB = 32'h10; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (10) @(posedge iCLK);
        #1 iKill = 1'b1;
        @(posedge iCLK); #1;
        iKill = 1'b0;
        check("kill ready", 32'(oReady), 32'd1);
        check("kill valid", 32'(oValid), 32'd0);
        check("kill result_kept", oResult, prev);
        run_op("mul_3x4_after_kill", OPMUL, 32'd3, 32'd4, 32'd12, 33);

        // kill and start together in IDLE: nothing accepted
        iControl = OPMUL; iA = 32'd9; iB = 32'd9; iStart = 1'b1; iKill = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0; iKill = 1'b0;
        check("kill_start ready", 32'(oReady), 32'd1);
        @(posedge iCLK); #1;
        check("kill_start no_valid", 32'(oValid), 32'd0);
        check("kill_start result", oResult, 32'd12);

        // reference-model sweep
        for (int i = 0; i < 200; i++) begin
            op = OPMUL + 5'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 3) b = 32'd0;
            if (i % 8 == 6) b = 32'($urandom_range(1, 15));
            if (i % 16 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op($sformatf("rand%0d", i), op, a, b, ref_model(op, a, b), lat_of(op, a, b));
        end

        // asynchronous reset in the middle of a divide
        run_op("mul_pre_rst", OPMUL, 32'd3, 32'd4, 32'd12, 33);
        iControl = OPDIV; iA = 32'd1000; iB = 32'd3; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (5) @(posedge iCLK);
        #4 iRST = 1'b1;
        #1;
        check("arst ready", 32'(oReady), 32'd1);
        check("arst valid", 32'(oValid), 32'd0);
        check("arst result", oResult, 32'd0);
        @(posedge iCLK);
        #3 iRST = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge iCLK); #1;
            if (oValid) vcount++;
        end
        check("arst no_valid", 32'(vcount), 32'd0);
        check("arst ready_after", 32'(oReady), 32'd1);
        run_op("divu_after_rst", OPDIVU, 32'd100, 32'd7, 32'd14, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
